// File: rtl/ysyx_041514_mem_access_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_041514_mem_access_pkg
//   Shared definitions for the MEM stage.
//   - memop_e   : memory opcode encodings (NONE, LB..LD, LBU..LWU, SB..SD)
//   - state_e   : MEM-stage transaction FSM states
//   - helpers   : opcode decode, load/store class, access size, strobe mask,
//                 misalignment check
// ---------------------------------------------------------------------------
package ysyx_041514_mem_access_pkg;

  localparam int MEMOP_W = 4;

  typedef enum logic [MEMOP_W-1:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LH   = 4'd2,
    MEMOP_LW   = 4'd3,
    MEMOP_LD   = 4'd4,
    MEMOP_LBU  = 4'd5,
    MEMOP_LHU  = 4'd6,
    MEMOP_LWU  = 4'd7,
    MEMOP_SB   = 4'd8,
    MEMOP_SH   = 4'd9,
    MEMOP_SW   = 4'd10,
    MEMOP_SD   = 4'd11
  } memop_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // Encodings 12..15 are folded into NONE so nothing downstream ever sees
  // an out-of-range enum value.
  function automatic memop_e decode_op(input logic [MEMOP_W-1:0] raw);
    memop_e op;
    case (raw)
      4'd1:    op = MEMOP_LB;
      4'd2:    op = MEMOP_LH;
      4'd3:    op = MEMOP_LW;
      4'd4:    op = MEMOP_LD;
      4'd5:    op = MEMOP_LBU;
      4'd6:    op = MEMOP_LHU;
      4'd7:    op = MEMOP_LWU;
      4'd8:    op = MEMOP_SB;
      4'd9:    op = MEMOP_SH;
      4'd10:   op = MEMOP_SW;
      4'd11:   op = MEMOP_SD;
      default: op = MEMOP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic op_is_load(input memop_e op);
    return op inside {MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LD,
                      MEMOP_LBU, MEMOP_LHU, MEMOP_LWU};
  endfunction

  function automatic logic op_is_store(input memop_e op);
    return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW, MEMOP_SD};
  endfunction

  // log2 of the access size in bytes: 0=byte, 1=half, 2=word, 3=double.
  function automatic logic [1:0] op_size_log2(input memop_e op);
    logic [1:0] s;
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: s = 2'd1;
      MEMOP_LW, MEMOP_LWU, MEMOP_SW: s = 2'd2;
      MEMOP_LD, MEMOP_SD:            s = 2'd3;
      default:                       s = 2'd0;
    endcase
    return s;
  endfunction

  // Byte-enable pattern for an access at lane 0.
  function automatic logic [7:0] size_mask(input memop_e op);
    logic [7:0] m;
    case (op_size_log2(op))
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input memop_e op, input logic [2:0] lo);
    logic mis;
    case (op_size_log2(op))
      2'd1:    mis = lo[0];
      2'd2:    mis = |lo[1:0];
      2'd3:    mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_041514_mem_access_if.sv
// ---------------------------------------------------------------------------
// ysyx_041514_mem_access_if
//   Single-outstanding data-bus handshake between the MEM stage (master)
//   and the data memory / interconnect (slave).
//   req_valid/req_ready : request handshake
//   addr                : 8-byte-aligned address
//   we                  : 1 = write
//   wdata/wstrb         : lane-shifted store data and byte strobes
//   resp_valid/rdata    : response (reads and writes), full doubleword
// ---------------------------------------------------------------------------
interface ysyx_041514_mem_access_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] addr;
  logic            we;
  logic [XLEN-1:0] wdata;
  logic [7:0]      wstrb;
  logic            resp_valid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req_valid, addr, we, wdata, wstrb,
    input  req_ready, resp_valid, rdata
  );

  modport slave (
    input  req_valid, addr, we, wdata, wstrb,
    output req_ready, resp_valid, rdata
  );
endinterface

// File: rtl/ysyx_041514_mem_access_load_align.sv
// ---------------------------------------------------------------------------
// ysyx_041514_load_align
//   Combinational load-data alignment: shifts the returned doubleword right
//   by the byte offset, truncates to the access size and sign/zero-extends.
//   rdata_i  : full aligned doubleword from the bus
//   offset_i : address bits [2:0] of the access
//   op_i     : load opcode
//   data_o   : write-back value
// ---------------------------------------------------------------------------
module ysyx_041514_load_align
  import ysyx_041514_mem_access_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      offset_i,
  input  memop_e          op_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned infers a latch.
    shifted = rdata_i >> {offset_i, 3'b000};
    data_o  = '0;
    case (op_i)
      MEMOP_LB:  data_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      MEMOP_LH:  data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      MEMOP_LW:  data_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      MEMOP_LBU: data_o = {{(XLEN-8){1'b0}},         shifted[7:0]};
      MEMOP_LHU: data_o = {{(XLEN-16){1'b0}},        shifted[15:0]};
      MEMOP_LWU: data_o = {{(XLEN-32){1'b0}},        shifted[31:0]};
      MEMOP_LD:  data_o = shifted;
      default:   data_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_041514_mem_access.sv
// ---------------------------------------------------------------------------
// ysyx_041514_mem_access
//   MEM pipeline stage: issues one data-bus transaction per load/store,
//   aligns load data, stalls upstream while busy and flags misalignment.
//   clk, rst          : clock, synchronous active-high reset
//   op_valid_i        : EX/MEM slot holds a live instruction
//   mem_op_i          : memory opcode
//   addr_i, wdata_i   : effective address, store data (rs2)
//   flush_i           : kill the current instruction
//   bus               : data-bus master (req/resp handshake)
//   load_data_o       : extended load result
//   mem_done_o        : one-cycle completion pulse
//   mem_stall_req_o   : hold upstream stages
//   load_misalign_o,
//   store_misalign_o  : one-cycle trap pulses
// ---------------------------------------------------------------------------
module ysyx_041514_mem_access
  import ysyx_041514_mem_access_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int MEMOP_LEN = MEMOP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid_i,
  input  logic [MEMOP_LEN-1:0] mem_op_i,
  input  logic [XLEN-1:0]      addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic                 flush_i,
  ysyx_041514_mem_access_if.master bus,
  output logic [XLEN-1:0]      load_data_o,
  output logic                 mem_done_o,
  output logic                 mem_stall_req_o,
  output logic                 load_misalign_o,
  output logic                 store_misalign_o
);

  state_e          state_q;
  memop_e          op_q;
  logic [2:0]      offset_q;
  logic            req_valid_q;
  logic [XLEN-1:0] bus_addr_q;
  logic            we_q;
  logic [XLEN-1:0] wdata_q;
  logic [7:0]      wstrb_q;
  logic [XLEN-1:0] load_data_q;
  logic            done_q;
  logic            load_mis_q;
  logic            store_mis_q;

  memop_e          op_in;
  logic            start;
  logic            misaligned;
  logic [XLEN-1:0] aligned_data;

  assign op_in      = decode_op(mem_op_i);
  assign misaligned = is_misaligned(op_in, addr_i[2:0]);

  // In the done cycle upstream is still presenting the instruction that just
  // completed (it only advances at the end of that cycle), so it must not be
  // sampled again.
  assign start = (state_q == S_IDLE) & op_valid_i & (op_in != MEMOP_NONE)
               & ~flush_i & ~done_q;

  assign mem_stall_req_o = (state_q != S_IDLE) | (start & ~misaligned);

  ysyx_041514_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata_i  (bus.rdata),
    .offset_i (offset_q),
    .op_i     (op_q),
    .data_o   (aligned_data)
  );

  // NOTE: state is updated with non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= MEMOP_NONE;
      offset_q    <= '0;
      req_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      load_mis_q  <= 1'b0;
      store_mis_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      load_mis_q  <= 1'b0;
      store_mis_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (misaligned) begin
              load_mis_q  <= op_is_load(op_in);
              store_mis_q <= op_is_store(op_in);
            end else begin
              op_q        <= op_in;
              offset_q    <= addr_i[2:0];
              bus_addr_q  <= {addr_i[XLEN-1:3], 3'b000};
              we_q        <= op_is_store(op_in);
              // Lane placement is computed once here so the bus fields are
              // plain registers, stable for the whole request phase.
              wdata_q     <= op_is_store(op_in) ? (wdata_i << {addr_i[2:0], 3'b000}) : '0;
              wstrb_q     <= op_is_store(op_in) ? (size_mask(op_in) << addr_i[2:0]) : '0;
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // An accepted request owes a response even if the instruction is
          // killed in the same cycle, hence DRAIN rather than IDLE.
          if (bus.req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= flush_i ? S_DRAIN : S_RESP;
          end else if (flush_i) begin
            req_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        S_RESP: begin
          if (bus.resp_valid) begin
            state_q <= S_IDLE;
            if (!flush_i) begin
              done_q <= 1'b1;
              if (op_is_load(op_q)) begin
                load_data_q <= aligned_data;
              end
            end
          end else if (flush_i) begin
            state_q <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (bus.resp_valid) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_valid    = req_valid_q;
  assign bus.addr         = bus_addr_q;
  assign bus.we           = we_q;
  assign bus.wdata        = wdata_q;
  assign bus.wstrb        = wstrb_q;
  assign load_data_o      = load_data_q;
  assign mem_done_o       = done_q;
  assign load_misalign_o  = load_mis_q;
  assign store_misalign_o = store_mis_q;

endmodule

// File: tb/tb_ysyx_041514_mem_access.sv
// ---------------------------------------------------------------------------
// tb_ysyx_041514_mem_access
//   Randomised bench for the MEM stage. A driver issues ops and plays the bus
//   slave; expected bus requests, completions and trap pulses are queued and
//   a negedge monitor pops and compares them as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_ysyx_041514_mem_access;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            op_valid_i;
  logic [3:0]      mem_op_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] wdata_i;
  logic            flush_i;
  logic [XLEN-1:0] load_data_o;
  logic            mem_done_o;
  logic            mem_stall_req_o;
  logic            load_misalign_o;
  logic            store_misalign_o;

  ysyx_041514_mem_access_if #(.XLEN(XLEN)) bus ();

  ysyx_041514_mem_access #(
    .XLEN      (XLEN),
    .MEMOP_LEN (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .op_valid_i       (op_valid_i),
    .mem_op_i         (mem_op_i),
    .addr_i           (addr_i),
    .wdata_i          (wdata_i),
    .flush_i          (flush_i),
    .bus              (bus),
    .load_data_o      (load_data_o),
    .mem_done_o       (mem_done_o),
    .mem_stall_req_o  (mem_stall_req_o),
    .load_misalign_o  (load_misalign_o),
    .store_misalign_o (store_misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic        is_ld;
    logic [63:0] data;
  } done_t;

  req_t        req_q[$];
  done_t       done_q[$];
  logic        mis_q[$];   // 1 = store misalign expected, 0 = load
  int          total = 0;
  int          bad   = 0;
  logic [63:0] model_ld = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd5, 4'd8:  return 1;
      4'd2, 4'd6, 4'd9:  return 2;
      4'd3, 4'd7, 4'd10: return 4;
      4'd4, 4'd11:       return 8;
      default:           return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_load(input logic [3:0] op, input logic [63:0] addr,
                                           input logic [63:0] rdata);
    int          sz  = ref_size(op);
    int          off = int'(addr[2:0]);
    bit          sgn = (op == 4'd1) || (op == 4'd2) || (op == 4'd3);
    logic [63:0] v   = '0;
    for (int b = 0; b < sz; b++) v[8*b +: 8] = rdata[8*(off+b) +: 8];
    if (sgn && v[8*sz-1]) begin
      for (int b = sz; b < 8; b++) v[8*b +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, bus.req_valid, 0);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_we"}, bus.we, 0);
    check({tag, "_wdata"}, bus.wdata, 0);
    check({tag, "_wstrb"}, bus.wstrb, 0);
    check({tag, "_load_data"}, load_data_o, 0);
    check({tag, "_done"}, mem_done_o, 0);
    check({tag, "_stall"}, mem_stall_req_o, 0);
    check({tag, "_misalign"}, {load_misalign_o, store_misalign_o}, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    req_t  r;
    done_t d;
    logic  m;
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) begin
        if (req_q.size() == 0) check("unexpected_req", bus.req_valid, 0);
        else begin
          r = req_q.pop_front();
          check("req_addr", bus.addr, r.addr);
          check("req_we", bus.we, r.we);
          check("req_wdata", bus.wdata, r.wdata);
          check("req_wstrb", bus.wstrb, r.wstrb);
        end
      end
      if (mem_done_o) begin
        if (done_q.size() == 0) check("unexpected_done", mem_done_o, 0);
        else begin
          d = done_q.pop_front();
          if (d.is_ld) check("load_data", load_data_o, d.data);
        end
      end
      if (load_misalign_o || store_misalign_o) begin
        if (mis_q.size() == 0) check("unexpected_misalign", {load_misalign_o, store_misalign_o}, 0);
        else begin
          m = mis_q.pop_front();
          check("misalign_kind", {load_misalign_o, store_misalign_o}, {~m, m});
        end
      end
    end
  end

  // ---------------- driver ----------------
  // fmode: 0 none, 1 flush in REQ before accept, 2 flush with ready,
  //        3 flush in RESP before response, 4 flush with response
  task automatic run_op(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input int rdy_dly, input int resp_dly,
                        input int fmode);
    int   sz    = ref_size(op);
    int   off   = int'(addr[2:0]);
    bit   is_st = (op >= 4'd8) && (op <= 4'd11);
    bit   is_ld = (op >= 4'd1) && (op <= 4'd7);
    bit   mis   = (sz > 1) && ((int'(addr[2:0]) % sz) != 0);
    req_t r;

    op_valid_i = 1'b1;
    mem_op_i   = op;
    addr_i     = addr;
    wdata_i    = wdata;

    if (!is_ld && !is_st) begin
      @(negedge clk);
      check("none_stall", mem_stall_req_o, 0);
      step();
      op_valid_i = 1'b0;
      @(negedge clk);
      check("none_no_req", bus.req_valid, 0);
      step();
      return;
    end

    if (mis) begin
      mis_q.push_back(is_st);
      @(negedge clk);
      check("mis_stall", mem_stall_req_o, 0);
      step();
      op_valid_i = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check("mis_no_req", bus.req_valid, 0);
        step();
      end
      check("mis_pulse_seen", mis_q.size(), 0);
      return;
    end

    r.addr  = {addr[63:3], 3'b000};
    r.we    = is_st;
    r.wdata = is_st ? (wdata << (8*off)) : '0;
    r.wstrb = '0;
    if (is_st) for (int b = 0; b < sz; b++) r.wstrb[off+b] = 1'b1;
    if (fmode != 1) req_q.push_back(r);

    @(negedge clk);
    check("start_stall", mem_stall_req_o, 1);
    step();

    if (fmode == 1) begin
      flush_i    = 1'b1;
      op_valid_i = 1'b0;
      @(negedge clk);
      check("flushreq_valid", bus.req_valid, 1);
      step();
      flush_i = 1'b0;
      @(negedge clk);
      check("flushreq_dropped", bus.req_valid, 0);
      check("flushreq_stall", mem_stall_req_o, 0);
      step();
      check("flushreq_ld_hold", load_data_o, model_ld);
      return;
    end

    for (int k = 0; k < rdy_dly; k++) begin
      @(negedge clk);
      check("wait_valid", bus.req_valid, 1);
      check("wait_addr", bus.addr, r.addr);
      check("wait_wdata", bus.wdata, r.wdata);
      check("wait_wstrb", bus.wstrb, r.wstrb);
      check("wait_stall", mem_stall_req_o, 1);
      step();
    end

    bus.req_ready = 1'b1;
    if (fmode == 2) begin
      flush_i    = 1'b1;
      op_valid_i = 1'b0;
    end
    @(negedge clk);
    check("accept_valid", bus.req_valid, 1);
    step();
    bus.req_ready = 1'b0;
    flush_i       = 1'b0;

    if (fmode == 3) begin
      flush_i    = 1'b1;
      op_valid_i = 1'b0;
      @(negedge clk);
      check("flushresp_stall", mem_stall_req_o, 1);
      step();
      flush_i = 1'b0;
    end

    for (int k = 0; k < resp_dly; k++) begin
      @(negedge clk);
      check("resp_wait_stall", mem_stall_req_o, 1);
      check("resp_wait_no_req", bus.req_valid, 0);
      step();
    end

    bus.resp_valid = 1'b1;
    bus.rdata      = rdata;
    if (fmode == 4) begin
      flush_i    = 1'b1;
      op_valid_i = 1'b0;
    end
    if (fmode == 0) begin
      done_q.push_back({is_ld, ref_load(op, addr, rdata)});
      if (is_ld) model_ld = ref_load(op, addr, rdata);
    end
    @(negedge clk);
    check("resp_stall", mem_stall_req_o, 1);
    step();
    bus.resp_valid = 1'b0;
    bus.rdata      = {$urandom, $urandom};
    flush_i        = 1'b0;
    op_valid_i     = 1'b0;

    @(negedge clk);
    check("done_pulse", mem_done_o, (fmode == 0) ? 1 : 0);
    check("done_stall", mem_stall_req_o, 0);
    step();
    @(negedge clk);
    check("done_once", mem_done_o, 0);
    check("done_q_drained", done_q.size(), 0);
    check("ld_hold", load_data_o, model_ld);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  op;
    logic [63:0] a, wd, rd, amask;
    int          sz, fm;

    rst            = 1'b1;
    op_valid_i     = 1'b0;
    mem_op_i       = '0;
    addr_i         = '0;
    wdata_i        = '0;
    flush_i        = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.rdata      = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    step();

    // LB with sign extension, fastest path
    run_op(4'd1, 64'h0000_0000_8000_0003, '0, 64'h0000_0000_80FF_0000, 0, 0, 0);
    check("lb_value", model_ld, 64'hFFFF_FFFF_FFFF_FF80);
    // SH into the top half-word lane
    run_op(4'd9, 64'h0000_0000_8000_0006, 64'h1234, {$urandom, $urandom}, 0, 0, 0);
    // misaligned LW
    run_op(4'd3, 64'h0000_0000_8000_0002, '0, '0, 0, 0, 0);
    // LD with slow ready and delayed response
    run_op(4'd4, 64'h0000_0000_8000_0010, '0, 64'hDEAD_BEEF_CAFE_F00D, 3, 1, 0);
    // LWU killed in RESP
    run_op(4'd7, 64'h0000_0000_8000_0024, '0, 64'h1111_2222_3333_4444, 0, 1, 3);

    // reset while waiting for a response
    op_valid_i = 1'b1;
    mem_op_i   = 4'd4;
    addr_i     = 64'h0000_0000_8000_0040;
    req_q.push_back({64'h0000_0000_8000_0040, 1'b0, 64'h0, 8'h00});
    @(negedge clk);
    step();
    bus.req_ready = 1'b1;
    @(negedge clk);
    step();
    bus.req_ready = 1'b0;
    rst           = 1'b1;
    op_valid_i    = 1'b0;
    @(negedge clk);
    check("pre_rst_stall", mem_stall_req_o, 1);
    step();
    rst      = 1'b0;
    model_ld = '0;
    @(negedge clk);
    check_all_zero("mid_rst");
    step();

    run_op(4'd5, 64'h0000_0000_8000_0007, '0, 64'hAB00_0000_0000_0000, 0, 0, 0);
    check("lbu_value", load_data_o, 64'h0000_0000_0000_00AB);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      sz = ref_size(op);
      a  = {$urandom, $urandom};
      if (sz > 0 && $urandom_range(0, 3) != 0) begin
        amask = 64'(sz - 1);
        a     = a & ~amask;
      end
      wd = {$urandom, $urandom};
      if (sz > 0 && sz < 8) wd = wd & ((64'd1 << (8*sz)) - 64'd1);
      rd = {$urandom, $urandom};
      fm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_op(op, a, wd, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), fm);
    end

    repeat (3) step();
    check("final_req_q", req_q.size(), 0);
    check("final_done_q", done_q.size(), 0);
    check("final_mis_q", mis_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
